field_scan_sel: RTL

- Parametrised, registered successor to the team's combinational 16-bit enable-vector field selector.
- Captures a DATA_W-bit vector and splits it into NFIELD fields of FIELD_W bits each.
- Two modes: direct (emit one field chosen by index) and scan (stream every field in index order).
- Output uses a valid/ready handshake; sits between control-register logic and downstream decode/ML feature logic.

---
 rtl/field_scan_sel.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/field_scan_sel.sv
// Registered field selector: captures a DATA_W-bit vector and emits one field (direct) or all fields (scan)
// over a valid/ready handshake. Optional macro SKIP_ZERO_EN suppresses zero-valued fields during scan.
module field_scan_sel #(
   parameter  int DATA_W  = 16,
   parameter  int FIELD_W = 2,
   localparam int NFIELD  = DATA_W / FIELD_W,
   localparam int IDX_W   = $clog2(NFIELD)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic [DATA_W-1:0]  data_i,
   input  logic               start_i,
   input  logic               mode_i,
   input  logic [IDX_W-1:0]   sel_i,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FIELD_W-1:0] out_data,
   output logic [IDX_W-1:0]   out_idx,
   output logic               busy,
   output logic               done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFIELD - 1);

   typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN} state_e;

   state_e               state_q, state_d;
   logic [DATA_W-1:0]    vec_q, vec_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic                 out_valid_q, out_valid_d;
   logic [FIELD_W-1:0]   out_data_q, out_data_d;
   logic [IDX_W-1:0]     out_idx_q, out_idx_d;
   logic                 done_q, done_d;

   logic                 xfer;
   logic                 scan_step;
   logic [DATA_W-1:0]    cap_vec;
   logic [IDX_W-1:0]     start_idx;
   logic [IDX_W-1:0]     ptr_nxt;

   function automatic logic [FIELD_W-1:0] field_of(input logic [DATA_W-1:0] v,
                                                   input logic [IDX_W-1:0]  i);
      logic [DATA_W-1:0] sh;
      sh = v >> (int'(i) * FIELD_W);
      return sh[FIELD_W-1:0];
   endfunction

   // Whether a scanned field is presented to the consumer or silently stepped over.
   function automatic logic emit_field(input logic [FIELD_W-1:0] f);
`ifdef SKIP_ZERO_EN
      return (f != '0);
`else
      return (f == f);
`endif
   endfunction

   assign xfer    = out_valid_q && out_ready;
   assign cap_vec = load_i ? data_i : vec_q;
   assign ptr_nxt = ptr_q + IDX_W'(1);
   assign start_idx = mode_i ? '0 : sel_i;

   // A skipped field holds no valid data, so the pointer moves on without waiting for a transfer.
`ifdef SKIP_ZERO_EN
   assign scan_step = xfer || !out_valid_q;
`else
   assign scan_step = xfer;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         vec_q       <= '0;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start_i) state_d = mode_i ? S_SCAN : S_DIRECT;
         S_DIRECT: if (xfer) state_d = S_IDLE;
         S_SCAN:   if (scan_step && (ptr_q == LAST_IDX)) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      vec_d       = vec_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      done_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (load_i) vec_d = data_i;
            if (start_i) begin
               ptr_d       = '0;
               out_idx_d   = start_idx;
               out_data_d  = field_of(cap_vec, start_idx);
               out_valid_d = mode_i ? emit_field(field_of(cap_vec, '0)) : 1'b1;
            end
         end
         S_DIRECT: begin
            if (xfer) begin
               out_valid_d = 1'b0;
               done_d      = 1'b1;
            end
         end
         S_SCAN: begin
            if (scan_step) begin
               if (ptr_q == LAST_IDX) begin
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  ptr_d       = ptr_nxt;
                  out_idx_d   = ptr_nxt;
                  out_data_d  = field_of(vec_q, ptr_nxt);
                  out_valid_d = emit_field(field_of(vec_q, ptr_nxt));
               end
            end
         end
         default: begin
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      out_valid = out_valid_q;
      out_data  = out_data_q;
      out_idx   = out_idx_q;
      done      = done_q;
   end

endmodule
